// File: rtl/mmu_walk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_walk_arbiter
// Purpose  : Shares one system-RAM read port between the instruction-side
//            (port 0) and data-side (port 1) SV39 page-table walkers. Each
//            walker read pulse is latched as pending, pending reads are issued
//            one at a time with round-robin fairness, and the returned PTE is
//            routed back to the walker that asked for it.
// Ports    : clk, reset (async, active-high)
//            pN_addr/pN_read       walker N request (one-cycle pulse)
//            pN_rdata/pN_ready     walker N response (one-cycle pulse)
//            pN_fault              walker N watchdog timeout (with pN_ready)
//            mem_addr/mem_read     bus read request (one-cycle strobe)
//            mem_rdata/mem_ready   bus read response
//            busy                  transaction outstanding on the bus
//            grant_id              port owning the current/last transaction
// Options  : MMU_ARB_TIMEOUT_EN enables the WAIT-state watchdog, which
//            completes a stalled read with zero data and a fault pulse after
//            TIMEOUT_CYCLES cycles without mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mmu_walk_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_read,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ready,
    output logic              p0_fault,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_read,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              p1_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pend0;
    logic              r_pend1;
    logic [ADDR_W-1:0] r_paddr0;
    logic [ADDR_W-1:0] r_paddr1;
    logic              r_last;
    logic              r_grant;
    logic              r_mem_read;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_ready0;
    logic              r_ready1;

    logic              w_cap0;
    logic              w_cap1;
    logic              w_req0;
    logic              w_req1;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic              w_issue;
    logic              w_win;
    logic              w_done;
    logic              w_tmo;
    logic              w_fin;

`ifdef MMU_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fault0;
    logic               r_fault1;
`endif

    always_comb begin
        // A port that owns the bus transaction cannot queue a second read.
        w_cap0      = p0_read && !r_pend0 && !((r_state == ST_WAIT) && (r_grant == 1'b0));
        w_cap1      = p1_read && !r_pend1 && !((r_state == ST_WAIT) && (r_grant == 1'b1));
        // A request arriving this cycle competes for the bus immediately, so
        // an idle arbiter strobes mem_read on the very next cycle.
        w_req0      = r_pend0 || w_cap0;
        w_req1      = r_pend1 || w_cap1;
        w_addr0     = r_pend0 ? r_paddr0 : p0_addr;
        w_addr1     = r_pend1 ? r_paddr1 : p1_addr;
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_win       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_issue     = 1'b1;
                    w_win       = (w_req0 && w_req1) ? !r_last : w_req1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef MMU_ARB_TIMEOUT_EN
                else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_fin = w_done || w_tmo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend0    <= 1'b0;
            r_pend1    <= 1'b0;
            r_paddr0   <= '0;
            r_paddr1   <= '0;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_ready0   <= 1'b0;
            r_ready1   <= 1'b0;
        end else begin
            if (w_cap0) r_paddr0 <= p0_addr;
            if (w_cap1) r_paddr1 <= p1_addr;

            // Granting a port consumes its pending slot (including one that
            // is being captured in the same cycle).
            if (w_issue && !w_win)   r_pend0 <= 1'b0;
            else if (w_cap0)         r_pend0 <= 1'b1;
            if (w_issue && w_win)    r_pend1 <= 1'b0;
            else if (w_cap1)         r_pend1 <= 1'b1;

            r_mem_read <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_win ? w_addr1 : w_addr0;
                r_grant    <= w_win;
            end

            r_ready0 <= w_fin && !r_grant;
            r_ready1 <= w_fin && r_grant;
            if (w_fin) begin
                r_last <= r_grant;
                if (!r_grant) r_rdata0 <= w_done ? mem_rdata : '0;
                else          r_rdata1 <= w_done ? mem_rdata : '0;
            end
        end
    end

`ifdef MMU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_fault0 <= 1'b0;
            r_fault1 <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !w_fin) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_fault0 <= w_tmo && !r_grant;
            r_fault1 <= w_tmo && r_grant;
        end
    end

    assign p0_fault = r_fault0;
    assign p1_fault = r_fault1;
`else
    // No watchdog in this build: a read waits for mem_ready indefinitely and
    // TIMEOUT_CYCLES has no effect.
    generate
        if (TIMEOUT_CYCLES >= 0) begin : g_no_watchdog
            assign p0_fault = 1'b0;
            assign p1_fault = 1'b0;
        end
    endgenerate
`endif

    assign p0_rdata = r_rdata0;
    assign p0_ready = r_ready0;
    assign p1_rdata = r_rdata1;
    assign p1_ready = r_ready1;
    assign mem_addr = r_mem_addr;
    assign mem_read = r_mem_read;
    assign busy     = (r_state == ST_WAIT);
    assign grant_id = r_grant;

endmodule
`default_nettype wire
